// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the frame driver/capture blocks.
// Holds the AXI-side FSM encoding, the status bit layout and the chunk-count helper.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    SFE_IDLE    = 2'd0,
    SFE_REQ     = 2'd1,
    SFE_RELEASE = 2'd2
  } sfe_state_t;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_WR_DROP   = 2;
  localparam int STATUS_AP_DROP   = 3;
  localparam int STATUS_PTR_LSB   = 8;
  localparam int STATUS_PTR_MSB   = 15;

  function automatic int num_chunks(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/frame_cdc_handshake.sv
// Four-phase req/ack handshake between axi_clk and frame_clk, with the frame-side
// reset synchroniser (async assert, sync deassert) and req edge detection.
module frame_cdc_handshake (
  input  logic axi_clk,
  input  logic axi_resetn,
  input  logic frame_clk,
  input  logic req,
  output logic ack_sync,
  output logic frame_resetn,
  output logic load
);

  logic [1:0] rst_sync;
  logic [1:0] req_sync;
  logic       req_sync_d;
  logic       ack;
  logic [1:0] ack_sync_r;
  logic       req_rise;
  logic       req_fall;

  always_ff @(posedge frame_clk or negedge axi_resetn) begin
    if (!axi_resetn) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end

  assign frame_resetn = rst_sync[1];

  // req crosses into frame_clk through two stages; the third flop only feeds edge detection
  always_ff @(posedge frame_clk or negedge frame_resetn) begin
    if (!frame_resetn) begin
      req_sync   <= '0;
      req_sync_d <= 1'b0;
      ack        <= 1'b0;
    end else begin
      req_sync   <= {req_sync[0], req};
      req_sync_d <= req_sync[1];
      if (req_rise)      ack <= 1'b1;
      else if (req_fall) ack <= 1'b0;
    end
  end

  assign req_rise = req_sync[1] & ~req_sync_d;
  assign req_fall = ~req_sync[1] & req_sync_d;
  assign load     = req_rise;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) ack_sync_r <= '0;
    else             ack_sync_r <= {ack_sync_r[0], ack};
  end

  assign ack_sync = ack_sync_r[1];

endmodule

// File: rtl/single_frame_emit.sv
// AXI-to-frame_clk single-frame driver: chunked staging buffer pushed to frame_out via req/ack.
// Optional readback port set enabled by defining SINGLE_FRAME_EMIT_READBACK_EN.
//
// state       | meaning
// SFE_IDLE    | accepting chunk writes and apply
// SFE_REQ     | req high, waiting for ack from frame_clk side
// SFE_RELEASE | req low, waiting for ack to drop
module single_frame_emit
  import frame_buf_pkg::*;
#(
  parameter int FRAME_WIDTH = 256
) (
  input  logic                   axi_clk,
  input  logic                   axi_resetn,
  input  logic                   frame_clk,
  input  logic [31:0]            frame_write,
  input  logic                   frame_write_wrStrobe,
  input  logic                   apply,
  output logic [31:0]            status,
`ifdef SINGLE_FRAME_EMIT_READBACK_EN
  output logic [31:0]            frame_readback,
  input  logic                   frame_readback_rdStrobe,
`endif
  output logic [FRAME_WIDTH-1:0] frame_out,
  output logic                   frame_updated
);

  localparam int         NUM_CHUNKS = num_chunks(FRAME_WIDTH);
  localparam int         LAST_W     = FRAME_WIDTH - 32 * (NUM_CHUNKS - 1);
  localparam logic [7:0] LAST_IDX   = 8'(NUM_CHUNKS - 1);

  sfe_state_t             state, state_next;
  logic                   req;
  logic                   ack_sync;
  logic                   frame_resetn;
  logic                   load;
  logic [FRAME_WIDTH-1:0] staging, staging_next;
  logic [7:0]             write_ptr;
  logic                   frame_full;
  logic                   write_dropped;
  logic                   apply_dropped;
  logic                   idle;
  logic                   write_en;
  logic                   apply_accept;

  assign idle         = (state == SFE_IDLE);
  assign write_en     = frame_write_wrStrobe & idle;
  assign apply_accept = apply & idle;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= SFE_IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      req   <= (state_next == SFE_REQ);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SFE_IDLE:    if (apply)     state_next = SFE_REQ;
      SFE_REQ:     if (ack_sync)  state_next = SFE_RELEASE;
      SFE_RELEASE: if (!ack_sync) state_next = SFE_IDLE;
      default:                    state_next = SFE_IDLE;
    endcase
  end

  // Last chunk keeps only the bits that exist in the frame
  always_comb begin
    staging_next = staging;
    if (write_en) begin
      for (int i = 0; i < NUM_CHUNKS - 1; i++) begin
        if (write_ptr == 8'(i)) staging_next[32*i +: 32] = frame_write;
      end
      if (write_ptr == LAST_IDX) staging_next[FRAME_WIDTH-1 -: LAST_W] = frame_write[LAST_W-1:0];
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      staging       <= '0;
      write_ptr     <= '0;
      frame_full    <= 1'b0;
      write_dropped <= 1'b0;
      apply_dropped <= 1'b0;
    end else begin
      staging <= staging_next;
      if (apply_accept) begin
        write_ptr     <= '0;
        frame_full    <= 1'b0;
        write_dropped <= 1'b0;
        apply_dropped <= 1'b0;
      end else begin
        if (write_en) begin
          if (write_ptr == LAST_IDX) begin
            write_ptr  <= '0;
            frame_full <= 1'b1;
          end else begin
            write_ptr  <= write_ptr + 8'd1;
          end
        end
        if (frame_write_wrStrobe && !idle) write_dropped <= 1'b1;
        if (apply && !idle)                apply_dropped <= 1'b1;
      end
    end
  end

  always_comb begin
    status                                = '0;
    status[STATUS_BUSY]                   = ~idle;
    status[STATUS_FULL]                   = frame_full;
    status[STATUS_WR_DROP]                = write_dropped;
    status[STATUS_AP_DROP]                = apply_dropped;
    status[STATUS_PTR_MSB:STATUS_PTR_LSB] = write_ptr;
  end

  frame_cdc_handshake u_handshake (
    .axi_clk      (axi_clk),
    .axi_resetn   (axi_resetn),
    .frame_clk    (frame_clk),
    .req          (req),
    .ack_sync     (ack_sync),
    .frame_resetn (frame_resetn),
    .load         (load)
  );

  // staging is frozen from req rise to ack return, so this bus is quasi-static:
  // constrain with set_max_delay -datapath_only (one frame_clk period) from staging to frame_out.
  always_ff @(posedge frame_clk or negedge frame_resetn) begin
    if (!frame_resetn) begin
      frame_out     <= '0;
      frame_updated <= 1'b0;
    end else begin
      frame_updated <= load;
      if (load) frame_out <= staging;
    end
  end

`ifdef SINGLE_FRAME_EMIT_READBACK_EN
  logic [7:0]              rd_ptr;
  logic [32*NUM_CHUNKS-1:0] staging_pad;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn)                  rd_ptr <= '0;
    else if (apply_accept)            rd_ptr <= '0;
    else if (frame_readback_rdStrobe) rd_ptr <= (rd_ptr == LAST_IDX) ? 8'd0 : rd_ptr + 8'd1;
  end

  always_comb begin
    staging_pad                  = '0;
    staging_pad[FRAME_WIDTH-1:0] = staging;
    frame_readback               = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (rd_ptr == 8'(i)) frame_readback = staging_pad[32*i +: 32];
    end
  end
`endif

endmodule

// File: tb/tb_single_frame_emit.sv
// Scoreboard bench for single_frame_emit at FRAME_WIDTH=40 (two chunks).
// Define SINGLE_FRAME_EMIT_READBACK_EN to also exercise the readback ports.
`timescale 1ns/1ps
module tb_single_frame_emit;
  localparam int FW = 40;

  logic          axi_clk = 1'b0;
  logic          frame_clk = 1'b0;
  logic          axi_resetn = 1'b0;
  logic [31:0]   frame_write = '0;
  logic          frame_write_wrStrobe = 1'b0;
  logic          apply = 1'b0;
  logic [31:0]   status;
  logic [FW-1:0] frame_out;
  logic          frame_updated;
`ifdef SINGLE_FRAME_EMIT_READBACK_EN
  logic [31:0]   frame_readback;
  logic          frame_readback_rdStrobe = 1'b0;
`endif

  int axi_half = 5;
  int frame_half = 7;
  always #(axi_half) axi_clk = ~axi_clk;
  always #(frame_half) frame_clk = ~frame_clk;

  single_frame_emit #(.FRAME_WIDTH(FW)) dut (
    .axi_clk              (axi_clk),
    .axi_resetn           (axi_resetn),
    .frame_clk            (frame_clk),
    .frame_write          (frame_write),
    .frame_write_wrStrobe (frame_write_wrStrobe),
    .apply                (apply),
    .status               (status),
`ifdef SINGLE_FRAME_EMIT_READBACK_EN
    .frame_readback          (frame_readback),
    .frame_readback_rdStrobe (frame_readback_rdStrobe),
`endif
    .frame_out            (frame_out),
    .frame_updated        (frame_updated)
  );

  // Reference model: two 32-bit chunk slots, the last one only 8 bits wide
  logic [31:0]   m_chunk [2];
  int            m_ptr;
  bit            m_full, m_wd, m_ad;
  logic [FW-1:0] sb_q[$];
  logic [FW-1:0] exp_f;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] model_frame();
    return {m_chunk[1][7:0], m_chunk[0]};
  endfunction

  task automatic model_reset();
    m_chunk[0] = '0;
    m_chunk[1] = '0;
    m_ptr  = 0;
    m_full = 0;
    m_wd   = 0;
    m_ad   = 0;
    sb_q.delete();
  endtask

  task automatic model_write(input logic [31:0] d);
    m_chunk[m_ptr] = (m_ptr == 1) ? {24'h0, d[7:0]} : d;
    if (m_ptr == 1) begin
      m_ptr  = 0;
      m_full = 1;
    end else begin
      m_ptr = m_ptr + 1;
    end
  endtask

  task automatic model_apply();
    sb_q.push_back(model_frame());
    m_ptr  = 0;
    m_full = 0;
    m_wd   = 0;
    m_ad   = 0;
  endtask

  // One axi_clk-wide pulse of write and/or apply; busy says whether the DUT is mid-transfer
  task automatic op(input bit wr, input logic [31:0] d, input bit ap, input bit busy);
    @(negedge axi_clk);
    frame_write_wrStrobe = wr;
    frame_write          = d;
    apply                = ap;
    if (busy) begin
      if (wr) m_wd = 1;
      if (ap) m_ad = 1;
    end else begin
      if (wr) model_write(d);
      if (ap) model_apply();
    end
    @(negedge axi_clk);
    frame_write_wrStrobe = 1'b0;
    apply                = 1'b0;
  endtask

  task automatic check_status(input string name, input bit busy);
    logic [31:0] e;
    e = {16'h0, 8'(m_ptr), 4'h0, m_ad, m_wd, m_full, busy};
    check(name, status, e);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (status[0] == 1'b0) done = 1;
      else @(negedge axi_clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: busy still %b after 500 cycles, expected 0", name, status[0]);
    end
  endtask

  task automatic transfer(input string name);
    op(0, '0, 1, 0);
    check_status({name, "_busy"}, 1);
    wait_idle({name, "_idle"});
    check_status({name, "_done"}, 0);
  endtask

  task automatic do_reset();
    @(negedge axi_clk);
    axi_resetn = 1'b0;
    model_reset();
    #1;
    check("reset_status", status, 32'h0);
    check("reset_frame_out", frame_out, '0);
    repeat (4) @(negedge axi_clk);
    check("reset_updated", frame_updated, 1'b0);
    axi_resetn = 1'b1;
    repeat (6) @(negedge frame_clk);
    @(negedge axi_clk);
  endtask

  always @(negedge frame_clk) begin
    if (frame_updated === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_updated: frame_out %h with nothing pending", frame_out);
      end else begin
        exp_f = sb_q.pop_front();
        check("frame_out", frame_out, exp_f);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge axi_clk);
    #1;
    check("por_status", status, 32'h0);
    check("por_frame_out", frame_out, '0);
    check("por_updated", frame_updated, 1'b0);
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    repeat (6) @(negedge frame_clk);

    // full frame
    op(1, 32'hDEADBEEF, 0, 0);
    op(1, 32'hFFFFFFA5, 0, 0);
    check_status("t1_full", 0);
    transfer("t1");

    // incomplete frame keeps upper byte
    op(1, 32'h12345678, 0, 0);
    check_status("t2_partial", 0);
    transfer("t2");

    // drops while busy
    op(1, 32'h0BADF00D, 0, 0);
    op(0, '0, 1, 0);
    op(1, 32'h00000000, 1, 1);
    check_status("t3_drops", 1);
    wait_idle("t3_idle");
    check_status("t3_flags", 0);
    transfer("t3_clear");

    // same-cycle write and apply
    op(1, 32'h55667788, 0, 0);
    op(1, 32'h000000C3, 1, 0);
    check_status("t4_busy", 1);
    wait_idle("t4_idle");
    check_status("t4_ptr", 0);

    // reset in REQ at both clock ratios, then a normal transfer
    for (int r = 0; r < 2; r++) begin
      axi_half   = (r == 0) ? 3 : 9;
      frame_half = (r == 0) ? 9 : 3;
      repeat (4) @(negedge axi_clk);
      op(1, 32'hCAFEF00D, 0, 0);
      op(0, '0, 1, 0);
      check_status("t5_req", 1);
      do_reset();
      op(1, 32'h01020304, 0, 0);
      op(1, 32'h000000E7, 0, 0);
      transfer("t5_after");
    end
    axi_half   = 5;
    frame_half = 7;

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int          k;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k <= 4) begin
        op(1, d, 0, 0);
        check_status("rnd_write", 0);
      end else if (k <= 6) begin
        transfer("rnd_apply");
      end else if (k == 7) begin
        op(1, d, 1, 0);
        check_status("rnd_both", 1);
        wait_idle("rnd_both_idle");
        check_status("rnd_both_done", 0);
      end else begin
        op(0, '0, 1, 0);
        op($urandom_range(0, 1), d, $urandom_range(0, 1), 1);
        check_status("rnd_drop", 1);
        wait_idle("rnd_drop_idle");
        check_status("rnd_drop_done", 0);
      end
    end

`ifdef SINGLE_FRAME_EMIT_READBACK_EN
    transfer("t6_prep");
    op(1, 32'hA1A2A3A4, 0, 0);
    op(1, 32'hB1B2B3B4, 0, 0);
    #1;
    check("t6_rd0", frame_readback, m_chunk[0]);
    for (int j = 1; j <= 2; j++) begin
      @(negedge axi_clk);
      frame_readback_rdStrobe = 1'b1;
      @(negedge axi_clk);
      frame_readback_rdStrobe = 1'b0;
      #1;
      check("t6_rd", frame_readback, m_chunk[j % 2]);
    end
`endif

    repeat (20) @(negedge frame_clk);
    check("frames_pending", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
